// File: rtl/equeue_gen.sv
// Issue queue: compacting age-ordered entries, CDB wakeup, oldest-ready select, flush.
// Optional CDB_DISPATCH_BYPASS_EN: capture same-cycle CDB results for operands being dispatched.
module equeue_gen #(
    parameter  int DEPTH    = 4,
    parameter  int OPCODE_W = 4,
    parameter  int TAG_W    = 6,
    parameter  int DATA_W   = 32,
    parameter  int NUM_CDB  = 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dispatch_en,
    output logic                      dispatch_ready,
    input  logic [OPCODE_W-1:0]       dispatch_opcode,
    input  logic [TAG_W-1:0]          dispatch_rdtag,
    input  logic [TAG_W-1:0]          dispatch_rstag,
    input  logic [TAG_W-1:0]          dispatch_rttag,
    input  logic [DATA_W-1:0]         dispatch_rsdata,
    input  logic [DATA_W-1:0]         dispatch_rtdata,
    input  logic                      dispatch_rsvalid,
    input  logic                      dispatch_rtvalid,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    input  logic                      flush,
    output logic                      issue_ready,
    output logic [OPCODE_W-1:0]       issue_opcode,
    output logic [TAG_W-1:0]          issue_rdtag,
    output logic [DATA_W-1:0]         issue_rsdata,
    output logic [DATA_W-1:0]         issue_rtdata,
    input  logic                      issue_done,
    output logic [CNT_W-1:0]          occupancy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OPCODE_W-1:0] opcode_q [DEPTH], opcode_d [DEPTH];
    logic [TAG_W-1:0]    rdtag_q  [DEPTH], rdtag_d  [DEPTH];
    logic [TAG_W-1:0]    rstag_q  [DEPTH], rstag_d  [DEPTH];
    logic [TAG_W-1:0]    rttag_q  [DEPTH], rttag_d  [DEPTH];
    logic [DATA_W-1:0]   rsdata_q [DEPTH], rsdata_d [DEPTH];
    logic [DATA_W-1:0]   rtdata_q [DEPTH], rtdata_d [DEPTH];
    logic                rsv_q    [DEPTH], rsv_d    [DEPTH];
    logic                rtv_q    [DEPTH], rtv_d    [DEPTH];
    logic [CNT_W-1:0]    count_q, count_d;

    logic [DATA_W-1:0]   rsdata_w [DEPTH];
    logic [DATA_W-1:0]   rtdata_w [DEPTH];
    logic                rsv_w    [DEPTH];
    logic                rtv_w    [DEPTH];

    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic                issue_fire;
    logic                accept;
    logic [CNT_W-1:0]    widx;
    logic                d_rsv, d_rtv;
    logic [DATA_W-1:0]   d_rsdata, d_rtdata;

    // Wakeup view of every entry; descending port loop lets the lowest port win.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rsv_w[i]    = rsv_q[i];
            rtv_w[i]    = rtv_q[i];
            rsdata_w[i] = rsdata_q[i];
            rtdata_w[i] = rtdata_q[i];
            if (CNT_W'(i) < count_q) begin
                for (int k = NUM_CDB - 1; k >= 0; k--) begin
                    if (cdb_valid[k] && !rsv_q[i] && cdb_tag[k*TAG_W +: TAG_W] == rstag_q[i]) begin
                        rsv_w[i]    = 1'b1;
                        rsdata_w[i] = cdb_data[k*DATA_W +: DATA_W];
                    end
                    if (cdb_valid[k] && !rtv_q[i] && cdb_tag[k*TAG_W +: TAG_W] == rttag_q[i]) begin
                        rtv_w[i]    = 1'b1;
                        rtdata_w[i] = cdb_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CNT_W'(i) < count_q && rsv_q[i] && rtv_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_ready    = sel_found;
    assign issue_opcode   = sel_found ? opcode_q[sel_idx] : '0;
    assign issue_rdtag    = sel_found ? rdtag_q[sel_idx]  : '0;
    assign issue_rsdata   = sel_found ? rsdata_q[sel_idx] : '0;
    assign issue_rtdata   = sel_found ? rtdata_q[sel_idx] : '0;
    assign dispatch_ready = (count_q < CNT_W'(DEPTH));
    assign occupancy      = count_q;
    assign issue_fire     = issue_done && sel_found;
    assign accept         = dispatch_en && dispatch_ready;

    always_comb begin
        d_rsv    = dispatch_rsvalid;
        d_rtv    = dispatch_rtvalid;
        d_rsdata = dispatch_rsdata;
        d_rtdata = dispatch_rtdata;
`ifdef CDB_DISPATCH_BYPASS_EN
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && !dispatch_rsvalid && cdb_tag[k*TAG_W +: TAG_W] == dispatch_rstag) begin
                d_rsv    = 1'b1;
                d_rsdata = cdb_data[k*DATA_W +: DATA_W];
            end
            if (cdb_valid[k] && !dispatch_rtvalid && cdb_tag[k*TAG_W +: TAG_W] == dispatch_rttag) begin
                d_rtv    = 1'b1;
                d_rtdata = cdb_data[k*DATA_W +: DATA_W];
            end
        end
`endif
    end

    // Shift entries above the issued one down, then drop the new op into the first free slot.
    always_comb begin
        int src;
        widx    = count_q - CNT_W'(issue_fire);
        count_d = count_q + CNT_W'(accept) - CNT_W'(issue_fire);
        for (int i = 0; i < DEPTH; i++) begin
            src = (issue_fire && i >= int'(sel_idx)) ? i + 1 : i;
            if (src < DEPTH) begin
                opcode_d[i] = opcode_q[IDX_W'(src)];
                rdtag_d[i]  = rdtag_q[IDX_W'(src)];
                rstag_d[i]  = rstag_q[IDX_W'(src)];
                rttag_d[i]  = rttag_q[IDX_W'(src)];
                rsdata_d[i] = rsdata_w[IDX_W'(src)];
                rtdata_d[i] = rtdata_w[IDX_W'(src)];
                rsv_d[i]    = rsv_w[IDX_W'(src)];
                rtv_d[i]    = rtv_w[IDX_W'(src)];
            end else begin
                opcode_d[i] = opcode_q[i];
                rdtag_d[i]  = rdtag_q[i];
                rstag_d[i]  = rstag_q[i];
                rttag_d[i]  = rttag_q[i];
                rsdata_d[i] = rsdata_q[i];
                rtdata_d[i] = rtdata_q[i];
                rsv_d[i]    = 1'b0;
                rtv_d[i]    = 1'b0;
            end
            if (accept && CNT_W'(i) == widx) begin
                opcode_d[i] = dispatch_opcode;
                rdtag_d[i]  = dispatch_rdtag;
                rstag_d[i]  = dispatch_rstag;
                rttag_d[i]  = dispatch_rttag;
                rsdata_d[i] = d_rsdata;
                rtdata_d[i] = d_rtdata;
                rsv_d[i]    = d_rsv;
                rtv_d[i]    = d_rtv;
            end
            if (flush) begin
                rsv_d[i] = 1'b0;
                rtv_d[i] = 1'b0;
            end
        end
        if (flush) count_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opcode_q[i] <= '0;
                rdtag_q[i]  <= '0;
                rstag_q[i]  <= '0;
                rttag_q[i]  <= '0;
                rsdata_q[i] <= '0;
                rtdata_q[i] <= '0;
                rsv_q[i]    <= 1'b0;
                rtv_q[i]    <= 1'b0;
            end
        end else begin
            count_q  <= count_d;
            opcode_q <= opcode_d;
            rdtag_q  <= rdtag_d;
            rstag_q  <= rstag_d;
            rttag_q  <= rttag_d;
            rsdata_q <= rsdata_d;
            rtdata_q <= rtdata_d;
            rsv_q    <= rsv_d;
            rtv_q    <= rtv_d;
        end
    end
endmodule
